// File: rtl/ram_pkg.sv
// Shared defaults for the ram_port block and its response FIFO.
package ram_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 12;
    localparam int DEPTH_DEF  = 4096;
    localparam int RD_LAT_DEF = 1;
    localparam int BYTE_W     = 8;
endpackage

// File: rtl/ram_rsp_fifo.sv
// Small in-order FIFO that parks responses while the consumer is stalled.
module ram_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == CNT_FULL);
    assign empty    = (cnt == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = slots[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (!do_push && do_pop) cnt <= cnt - 1'b1;
        end
    end

    // Storage carries no reset so it maps onto plain register/LUT RAM.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ram_port.sv
// Valid/ready single-port RAM with byte enables, fixed read latency and a
// response FIFO sized so a stalled consumer never loses a response.
module ram_port
    import ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W/BYTE_W-1:0] req_be,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err
);
    localparam int BE_W    = DATA_W / BYTE_W;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OUT_MAX = RD_LAT + 1;
    localparam int CNT_W   = $clog2(OUT_MAX + 1);
    localparam int RSP_W   = DATA_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(OUT_MAX);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic              xfer;
    logic              in_range;
    logic              mem_en;
    logic              rsp_hs;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q;

    logic              s0_valid;
    logic              s0_err;
    logic              s0_rd;
    logic [DATA_W-1:0] s0_data;

    logic              last_valid;
    logic              last_err;
    logic [DATA_W-1:0] last_data;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [RSP_W-1:0]  fifo_head;
    logic [RSP_W-1:0]  rsp_head;

    assign idx       = req_addr[IDX_W-1:0];
    assign in_range  = ({1'b0, req_addr} < DEPTH_V);
    assign xfer      = req_valid && req_ready;
    assign mem_en    = xfer && in_range;
    assign rsp_valid = last_valid || !fifo_empty;
    assign rsp_hs    = rsp_valid && rsp_ready;
    // A full response path still accepts when a response leaves this cycle.
    assign req_ready = !rst && ((cnt < CNT_MAX) || rsp_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (xfer && !rsp_hs) begin
            cnt <= cnt + 1'b1;
        end else if (!xfer && rsp_hs) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Single-port block RAM, read-first, no reset on contents.
    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (req_we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (req_be[b]) mem[idx][b*BYTE_W +: BYTE_W] <= req_wdata[b*BYTE_W +: BYTE_W];
                end
            end else begin
                mem_q <= mem[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_err   <= 1'b0;
            s0_rd    <= 1'b0;
        end else begin
            s0_valid <= xfer;
            s0_err   <= xfer && !in_range;
            s0_rd    <= mem_en && !req_we;
        end
    end

    // Writes and errors respond with zero data; mem_q only matters for reads.
    assign s0_data = s0_rd ? mem_q : '0;

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign last_valid = s0_valid;
            assign last_err   = s0_err;
            assign last_data  = s0_data;
        end else begin : g_lat2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    last_valid <= 1'b0;
                    last_err   <= 1'b0;
                    last_data  <= '0;
                end else begin
                    last_valid <= s0_valid;
                    last_err   <= s0_err;
                    last_data  <= s0_data;
                end
            end
        end
    endgenerate

    // The last stage bypasses the FIFO only when nothing older is queued and
    // the consumer takes it now; otherwise it is parked behind older entries.
    assign fifo_pop  = !fifo_empty && rsp_ready;
    assign fifo_push = last_valid && !(fifo_empty && rsp_ready) && (!fifo_full || fifo_pop);

    ram_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (OUT_MAX)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({last_err, last_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_head  = fifo_empty ? {last_err, last_data} : fifo_head;
    assign rsp_err   = rsp_valid && rsp_head[DATA_W];
    assign rsp_rdata = rsp_valid ? rsp_head[DATA_W-1:0] : '0;
endmodule

// File: tb/tb_ram_port.sv
// Scoreboard bench for ram_port (DEPTH 3000, RD_LAT 2): directed vectors plus
// a random back-to-back burst checked against a byte-accurate memory model.
module tb_ram_port;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int DEP = 3000;
    localparam int LAT = 2;
    localparam int BW  = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [BW-1:0] req_be = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] model [4096];
    logic          prev_stall = 1'b0;
    logic          prev_err = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW:0]   mon_e;

    ram_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, after the driver has settled its inputs.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(rsp_valid), 64'd1);
                check("hold_data", 64'({rsp_err, rsp_rdata}), 64'({prev_err, prev_data}));
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("rsp_err", 64'(rsp_err), 64'(mon_e[DW]));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e[DW-1:0]));
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_err   = rsp_err;
            prev_data  = rsp_rdata;
        end
    end

    // Called at a falling edge; presents one request and records it if taken.
    task automatic drive_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input logic [BW-1:0] be, input logic hand, input logic [DW:0] hand_exp,
                             output logic acc);
        logic [DW:0] e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        #1;
        acc = req_ready;
        if (acc) begin
            if (int'(addr) >= DEP) begin
                e = {1'b1, {DW{1'b0}}};
            end else if (we) begin
                for (int b = 0; b < BW; b++) if (be[b]) model[addr][b*8 +: 8] = wd[b*8 +: 8];
                e = {1'b0, {DW{1'b0}}};
            end else begin
                e = {1'b0, model[addr]};
            end
            if (hand) e = hand_exp;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be, input logic hand, input logic [DW:0] hand_exp);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) begin
            drive_req(we, addr, wd, be, hand, hand_exp, acc);
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!acc) check("issue_timeout", 64'(acc), 64'd1);
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] wd, input logic [BW-1:0] be);
        issue(1'b1, AW'(addr), wd, be, 1'b0, '0);
    endtask

    task automatic rd_exp(input int addr, input logic [DW-1:0] d, input logic err);
        issue(1'b0, AW'(addr), '0, '0, 1'b1, {err, d});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic acc;
        int   n_acc;
        rst = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 check("ready_after_reset", 64'(req_ready), 64'd1);
        @(negedge clk);

        // Full-word write then read, with latency measured from acceptance.
        wr(5, 32'hDEADBEEF, 4'hF);
        idle(4);
        drive_req(1'b0, AW'(5), '0, '0, 1'b1, {1'b0, 32'hDEADBEEF}, acc);
        check("rd5_accept", 64'(acc), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("latency_early", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        #1 check("latency_on", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        idle(2);

        // Partial byte enables and an all-zero enable write.
        wr(7, 32'h11223344, 4'hF);
        wr(7, 32'hAABBCCDD, 4'h5);
        rd_exp(7, 32'h11BB33DD, 1'b0);
        wr(7, 32'hFFFFFFFF, 4'h0);
        rd_exp(7, 32'h11BB33DD, 1'b0);

        // Boundary at DEPTH.
        wr(2999, 32'h0BADF00D, 4'hF);
        issue(1'b1, AW'(3000), 32'h12345678, 4'hF, 1'b1, {1'b1, 32'h0});
        rd_exp(3000, 32'h0, 1'b1);
        rd_exp(2999, 32'h0BADF00D, 1'b0);
        idle(4);

        // Backpressure: only RD_LAT+1 reads fit while the consumer stalls.
        for (int i = 0; i < 5; i++) wr(20 + i, 32'hC0DE0000 + 32'(i), 4'hF);
        idle(4);
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, AW'(20 + i), '0, '0, 1'b1, {1'b0, 32'hC0DE0000 + 32'(i)}, acc);
            if (acc) n_acc++;
            @(negedge clk);
        end
        for (int i = 3; i < 5; i++) begin
            drive_req(1'b0, AW'(23), '0, '0, 1'b1, {1'b0, 32'hC0DE0003}, acc);
            if (acc) n_acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        #1;
        check("stall_accepts", 64'(n_acc), 64'd3);
        check("stall_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 2) begin
                drive_req(1'b0, AW'(23 + i), '0, '0, 1'b1, {1'b0, 32'hC0DE0003 + 32'(i)}, acc);
                check("stream_accept", 64'(acc), 64'd1);
            end else begin
                req_valid = 1'b0;
                #1;
            end
            check("stream_valid", 64'(rsp_valid), 64'd1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        idle(4);

        // Reset with two responses outstanding.
        rsp_ready = 1'b0;
        rd_exp(5, 32'hDEADBEEF, 1'b0);
        rd_exp(7, 32'h11BB33DD, 1'b0);
        idle(3);
        #1 check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1 check("post_rst_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        idle(5);
        rd_exp(5, 32'hDEADBEEF, 1'b0);
        idle(4);

        // Random back-to-back traffic against the model.
        for (int i = 0; i < 16; i++) wr(i, $urandom, 4'hF);
        for (int i = 2992; i < 3000; i++) wr(i, $urandom, 4'hF);
        for (int i = 0; i < 100; i++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 15));
            else                           a = AW'(2992 + $urandom_range(0, 15));
            drive_req(1'($urandom_range(0, 1)), a, $urandom, BW'($urandom_range(0, 15)),
                      1'b0, '0, acc);
            check("b2b_ready", 64'(acc), 64'd1);
            @(negedge clk);
        end
        req_valid = 1'b0;

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
